// File: rtl/ysyx_22051468_wb_gpr_pkg.sv
// Shared constants for the write-back / GPR block.
//   GPR_NUM      - number of architectural registers
//   GPR_ADDR_W   - register address width
//   WB_BUF_DEPTH - default write-back buffer depth
// A buffer entry is packed as {addr, data}, GPR_ADDR_W + WIDTH bits wide.
package ysyx_22051468_wb_gpr_pkg;

  localparam int GPR_NUM      = 32;
  localparam int GPR_ADDR_W   = 5;
  localparam int WB_BUF_DEPTH = 2;

  // A result occupies a buffer slot only if it really writes a register;
  // x0 is hardwired to zero and is never buffered.
  function automatic logic is_reg_write(input logic en,
                                        input logic [GPR_ADDR_W-1:0] addr);
    return en && (addr != '0);
  endfunction

endpackage

// File: rtl/ysyx_22051468_wb_fifo.sv
// Circular write-back buffer.
// Ports:
//   clk, rst        - clock, async active-high reset
//   push, push_data - enqueue request (ignored when full)
//   pop             - dequeue head (ignored when empty)
//   full, empty     - occupancy flags
//   head            - oldest entry
//   entries         - every physical slot, for the bypass search
//   valid           - per-slot valid vector
//   rd_idx          - slot index of the oldest entry
module ysyx_22051468_wb_fifo #(
  parameter int EW    = 69,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [EW-1:0]             push_data,
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic [EW-1:0]             head,
  output logic [DEPTH-1:0][EW-1:0]  entries,
  output logic [DEPTH-1:0]          valid,
  output logic [$clog2(DEPTH)-1:0]  rd_idx
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]              wr_ptr;
  logic [AW:0]              rd_ptr;
  logic [AW:0]              count;
  logic [DEPTH-1:0][EW-1:0] mem;
  logic                     do_push;
  logic                     do_pop;
  logic [AW-1:0]            offset;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_idx  = rd_ptr[AW-1:0];
  assign head    = mem[rd_ptr[AW-1:0]];
  assign entries = mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    valid  = '0;
    offset = '0;
    for (int s = 0; s < DEPTH; s++) begin
      offset   = AW'(s) - rd_ptr[AW-1:0];
      valid[s] = ({1'b0, offset} < count);
    end
  end

endmodule

// File: rtl/ysyx_22051468_wb_gpr.sv
// Write-back receiver and GPR file.
// Buffers Exec results, commits the oldest one per cycle into the register
// array, and serves two read ports with newest-first bypass from the buffer.
// Ports:
//   clk, rst                       - clock, async active-high reset
//   wb_valid_i / wb_ready_o        - Exec result handshake
//   w_addr_i, w_data_i, w_en_i     - Exec destination, data, write enable
//   commit_stall_i                 - hold the buffer head this cycle
//   rs1/rs2_addr_i, rs1/rs2_data_o - combinational operand read ports
//   pending_o                      - registers with an uncommitted write
//   commit_valid/addr/data_o       - registered record of the last commit
module ysyx_22051468_wb_gpr
  import ysyx_22051468_wb_gpr_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = WB_BUF_DEPTH,
  parameter int NREG  = GPR_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid_i,
  output logic                  wb_ready_o,
  input  logic [GPR_ADDR_W-1:0] w_addr_i,
  input  logic [WIDTH-1:0]      w_data_i,
  input  logic                  w_en_i,
  input  logic                  commit_stall_i,
  input  logic [GPR_ADDR_W-1:0] rs1_addr_i,
  input  logic [GPR_ADDR_W-1:0] rs2_addr_i,
  output logic [WIDTH-1:0]      rs1_data_o,
  output logic [WIDTH-1:0]      rs2_data_o,
  output logic [NREG-1:0]       pending_o,
  output logic                  commit_valid_o,
  output logic [GPR_ADDR_W-1:0] commit_addr_o,
  output logic [WIDTH-1:0]      commit_data_o
);

  localparam int EW = GPR_ADDR_W + WIDTH;
  localparam int AW = $clog2(DEPTH);

  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic [EW-1:0]            head;
  logic [DEPTH-1:0][EW-1:0] entries;
  logic [DEPTH-1:0]         valid;
  logic [AW-1:0]            rd_idx;
  logic [GPR_ADDR_W-1:0]    head_addr;
  logic [WIDTH-1:0]         head_data;
  logic [AW-1:0]            slot;
  logic [WIDTH-1:0]         gpr [NREG];

  // Ready depends on registered occupancy only, so a full buffer refuses
  // even when it drains in the same cycle.
  assign wb_ready_o = !full;
  assign push       = wb_valid_i && wb_ready_o && is_reg_write(w_en_i, w_addr_i);
  assign pop        = !empty && !commit_stall_i;
  assign head_addr  = head[EW-1:WIDTH];
  assign head_data  = head[WIDTH-1:0];

  ysyx_22051468_wb_fifo #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({w_addr_i, w_data_i}),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .entries   (entries),
    .valid     (valid),
    .rd_idx    (rd_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        gpr[r] <= '0;
      end
      commit_valid_o <= 1'b0;
      commit_addr_o  <= '0;
      commit_data_o  <= '0;
    end else begin
      commit_valid_o <= pop;
      if (pop) begin
        gpr[head_addr] <= head_data;
        commit_addr_o  <= head_addr;
        commit_data_o  <= head_data;
      end
    end
  end

  // Walk the buffer oldest to youngest; a later match overrides an earlier
  // one, so the youngest write to a register wins.
  always_comb begin
    rs1_data_o = gpr[rs1_addr_i];
    rs2_data_o = gpr[rs2_addr_i];
    slot       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_idx + AW'(i);
      if (valid[slot] && (entries[slot][EW-1:WIDTH] == rs1_addr_i)) begin
        rs1_data_o = entries[slot][WIDTH-1:0];
      end
      if (valid[slot] && (entries[slot][EW-1:WIDTH] == rs2_addr_i)) begin
        rs2_data_o = entries[slot][WIDTH-1:0];
      end
    end
    if (rs1_addr_i == '0) rs1_data_o = '0;
    if (rs2_addr_i == '0) rs2_data_o = '0;
  end

  always_comb begin
    pending_o = '0;
    for (int s = 0; s < DEPTH; s++) begin
      if (valid[s]) begin
        pending_o[entries[s][EW-1:WIDTH]] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22051468_wb_gpr.sv
module tb_ysyx_22051468_wb_gpr;

  localparam int WIDTH = 64;
  localparam int DEPTH = 2;
  localparam int NREG  = 32;

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_valid_i;
  logic             wb_ready_o;
  logic [4:0]       w_addr_i;
  logic [WIDTH-1:0] w_data_i;
  logic             w_en_i;
  logic             commit_stall_i;
  logic [4:0]       rs1_addr_i;
  logic [4:0]       rs2_addr_i;
  logic [WIDTH-1:0] rs1_data_o;
  logic [WIDTH-1:0] rs2_data_o;
  logic [NREG-1:0]  pending_o;
  logic             commit_valid_o;
  logic [4:0]       commit_addr_o;
  logic [WIDTH-1:0] commit_data_o;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: pending queue (oldest first), architectural array,
  // and the queue of commits the DUT is expected to report
  ent_t        q[$];
  ent_t        exp_q[$];
  logic [63:0] arr [NREG];

  // actions the upcoming clock edge will perform
  logic i_com;
  logic i_wr;
  ent_t i_ent;

  always #5 clk = ~clk;

  ysyx_22051468_wb_gpr #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .NREG  (NREG)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_valid_i     (wb_valid_i),
    .wb_ready_o     (wb_ready_o),
    .w_addr_i       (w_addr_i),
    .w_data_i       (w_data_i),
    .w_en_i         (w_en_i),
    .commit_stall_i (commit_stall_i),
    .rs1_addr_i     (rs1_addr_i),
    .rs2_addr_i     (rs2_addr_i),
    .rs1_data_o     (rs1_data_o),
    .rs2_data_o     (rs2_data_o),
    .pending_o      (pending_o),
    .commit_valid_o (commit_valid_o),
    .commit_addr_o  (commit_addr_o),
    .commit_data_o  (commit_data_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [4:0] a);
    if (a == 0) return 64'd0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a == a) return q[i].d;
    end
    return arr[a];
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] p;
    p = '0;
    foreach (q[i]) p[q[i].a] = 1'b1;
    return p;
  endfunction

  task automatic model_clear();
    q.delete();
    exp_q.delete();
    for (int r = 0; r < NREG; r++) arr[r] = '0;
    i_com = 1'b0;
    i_wr  = 1'b0;
  endtask

  task automatic apply_edge();
    ent_t e;
    if (i_com) begin
      e = q.pop_front();
      arr[e.a] = e.d;
      exp_q.push_back(e);
    end
    if (i_wr) q.push_back(i_ent);
    i_com = 1'b0;
    i_wr  = 1'b0;
  endtask

  // one clock: let the edge happen, then present the next cycle's inputs
  task automatic cycle(input logic v, input logic en, input logic [4:0] a,
                       input logic [63:0] d, input logic st,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    apply_edge();
    #1;
    wb_valid_i     = v;
    w_en_i         = en;
    w_addr_i       = a;
    w_data_i       = d;
    commit_stall_i = st;
    rs1_addr_i     = r1;
    rs2_addr_i     = r2;
    i_com   = (q.size() > 0) && !st;
    i_wr    = v && (q.size() < DEPTH) && en && (a != 0);
    i_ent.a = a;
    i_ent.d = d;
  endtask

  task automatic reset_checks(input logic [4:0] r1, input logic [4:0] r2);
    rs1_addr_i = r1;
    rs2_addr_i = r2;
    #1;
    check("rst_ready", {63'd0, wb_ready_o}, 64'd1);
    check("rst_pending", {32'd0, pending_o}, 64'd0);
    check("rst_rs1", rs1_data_o, 64'd0);
    check("rst_rs2", rs2_data_o, 64'd0);
    check("rst_commit_valid", {63'd0, commit_valid_o}, 64'd0);
    check("rst_commit_addr", {59'd0, commit_addr_o}, 64'd0);
    check("rst_commit_data", commit_data_o, 64'd0);
  endtask

  task automatic do_reset(input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    apply_edge();
    #1;
    rst        = 1'b1;
    wb_valid_i = 1'b0;
    model_clear();
    reset_checks(r1, r2);
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_checks(r1, r2);
  endtask

  // monitor / scoreboard: compares DUT outputs on the falling edge
  always @(negedge clk) begin
    ent_t e;
    if (!rst) begin
      check("ready", {63'd0, wb_ready_o}, {63'd0, (q.size() < DEPTH)});
      check("pending", {32'd0, pending_o}, {32'd0, model_pending()});
      check("rs1", rs1_data_o, model_read(rs1_addr_i));
      check("rs2", rs2_data_o, model_read(rs2_addr_i));
      if (commit_valid_o) begin
        if (exp_q.size() == 0) begin
          check("commit_spurious", {63'd0, commit_valid_o}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("commit_addr", {59'd0, commit_addr_o}, {59'd0, e.a});
          check("commit_data", commit_data_o, e.d);
        end
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("commit_missing", {63'd0, commit_valid_o}, 64'd1);
      end
    end
  end

  initial begin
    logic [4:0] ra;
    rst            = 1'b1;
    wb_valid_i     = 1'b0;
    w_en_i         = 1'b0;
    w_addr_i       = '0;
    w_data_i       = '0;
    commit_stall_i = 1'b0;
    rs1_addr_i     = '0;
    rs2_addr_i     = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset_checks(5'd5, 5'd7);
    rst = 1'b0;

    // basic write and bypass-then-commit
    cycle(1, 1, 5, 64'h1234, 0, 5, 0);
    cycle(0, 0, 0, 0, 0, 5, 0);
    cycle(0, 0, 0, 0, 0, 5, 6);

    // back-pressure: two entries held, third refused, ordered drain
    cycle(1, 1, 1, 64'd1, 1, 1, 2);
    cycle(1, 1, 2, 64'd2, 1, 1, 2);
    cycle(1, 1, 3, 64'd3, 1, 3, 2);
    cycle(1, 1, 3, 64'd3, 1, 3, 1);
    cycle(0, 0, 0, 0, 0, 1, 2);
    cycle(0, 0, 0, 0, 0, 1, 2);
    cycle(0, 0, 0, 0, 0, 3, 2);

    // two writes to the same register
    cycle(1, 1, 7, 64'hA, 1, 7, 0);
    cycle(1, 1, 7, 64'hB, 1, 7, 0);
    cycle(0, 0, 0, 0, 1, 7, 7);
    cycle(0, 0, 0, 0, 0, 7, 0);
    cycle(0, 0, 0, 0, 0, 7, 0);
    cycle(0, 0, 0, 0, 0, 7, 0);

    // x0 destination and non-writing results are dropped
    cycle(1, 1, 0, 64'hFF, 0, 0, 3);
    cycle(1, 0, 3, 64'h33, 0, 0, 3);
    cycle(0, 0, 0, 0, 0, 3, 0);
    cycle(0, 0, 0, 0, 0, 3, 0);

    // reset with two entries buffered
    cycle(1, 1, 9, 64'h99, 1, 9, 10);
    cycle(1, 1, 10, 64'hAA, 1, 9, 10);
    cycle(0, 0, 0, 0, 1, 9, 10);
    do_reset(5'd9, 5'd10);

    // streaming, no stall
    for (int i = 0; i < 20; i++) begin
      ra = 5'($urandom_range(1, 31));
      cycle(1, 1, ra, {$urandom, $urandom}, 0, ra, 5'($urandom));
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // random traffic; a small address pool makes bypass collisions common
    for (int i = 0; i < 600; i++) begin
      ra = 5'($urandom_range(0, 7));
      cycle(1'($urandom), ($urandom_range(0, 7) != 0), ra, {$urandom, $urandom},
            ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), 5'($urandom));
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0);

    // final architectural state through the read ports
    for (int r = 0; r < NREG; r += 2) begin
      cycle(0, 0, 0, 0, 0, 5'(r), 5'(r + 1));
    end
    @(posedge clk);
    apply_edge();
    @(negedge clk);
    #1;
    check("drain_empty", {58'd0, 6'(exp_q.size())}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
